// File: rtl/apu_pkg.sv
// Shared APU constants: default counter widths and the length-load decode.
package apu_pkg;

  localparam int unsigned LIN_WIDTH_D = 7;
  localparam int unsigned LEN_WIDTH_D = 8;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] len_decode(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by the APU channels: load, halt-gated decrement,
// held at zero while the channel is disabled.
module apu_length_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             halt,
  input  logic             enable,
  input  logic             tick,
  output logic [WIDTH-1:0] count
);

  // Disable beats load, and load beats a same-cycle decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (tick && !halt && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/apu_duration_counter.sv
// Linear counter plus length counter gating a waveform channel's sequencer.
// Build option: APU_LENGTH_TABLE_EN selects table-decoded length loads.
module apu_duration_counter
  import apu_pkg::*;
#(
  parameter int unsigned LIN_WIDTH       = LIN_WIDTH_D,
  parameter int unsigned LEN_WIDTH       = LEN_WIDTH_D,
  parameter int unsigned HALT_IS_CONTROL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lin_wr,
  input  logic                 ctrl_in,
  input  logic [LIN_WIDTH-1:0] reload_in,
  input  logic                 len_wr,
  input  logic [LEN_WIDTH-1:0] len_in,
  input  logic                 len_halt,
  input  logic                 enable,
  input  logic                 qtr_tick,
  input  logic                 half_tick,
  output logic [LIN_WIDTH-1:0] linear_count,
  output logic [LEN_WIDTH-1:0] length_count,
  output logic                 length_nz,
  output logic                 active
);

  logic                 ctrlFlag;
  logic                 reloadFlag;
  logic [LIN_WIDTH-1:0] reloadValue;
  logic [LIN_WIDTH-1:0] linearCount;
  logic [LEN_WIDTH-1:0] lenLoad;
  logic                 haltSrc;

  always_comb begin
`ifdef APU_LENGTH_TABLE_EN
    lenLoad = LEN_WIDTH'(len_decode(len_in[4:0]));
`else
    lenLoad = len_in;
`endif
  end

  assign haltSrc = (HALT_IS_CONTROL != 0) ? ctrlFlag : len_halt;

  // Ticks see pre-write flag/reload; a length write re-arms the flag over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlFlag    <= 1'b0;
      reloadFlag  <= 1'b0;
      reloadValue <= '0;
      linearCount <= '0;
    end else begin
      if (qtr_tick) begin
        if (reloadFlag) begin
          linearCount <= reloadValue;
        end else if (linearCount != '0) begin
          linearCount <= linearCount - LIN_WIDTH'(1);
        end
      end
      if (len_wr) begin
        reloadFlag <= 1'b1;
      end else if (qtr_tick && !ctrlFlag) begin
        reloadFlag <= 1'b0;
      end
      if (lin_wr) begin
        ctrlFlag    <= ctrl_in;
        reloadValue <= reload_in;
      end
    end
  end

  apu_length_counter #(
    .WIDTH (LEN_WIDTH)
  ) lengthCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (len_wr),
    .loadValue (lenLoad),
    .halt      (haltSrc),
    .enable    (enable),
    .tick      (half_tick),
    .count     (length_count)
  );

  assign linear_count = linearCount;
  assign length_nz    = (length_count != '0);
  assign active       = enable && (linearCount != '0) && (length_count != '0);

endmodule

// File: tb/tb_apu_duration_counter.sv
// Directed bench for apu_duration_counter: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_apu_duration_counter;

  localparam int unsigned LW = 7;
  localparam int unsigned NW = 8;

`ifdef APU_LENGTH_TABLE_EN
  localparam int LEN_A = 48;   // len_in = 20
  localparam int LEN_B = 254;  // len_in = 33 (upper bits ignored)
  localparam int LEN_B3 = 251;
  localparam int LEN_C = 4;    // len_in = 5
`else
  localparam int LEN_A = 20;
  localparam int LEN_B = 33;
  localparam int LEN_B3 = 30;
  localparam int LEN_C = 5;
`endif

  typedef struct {
    string name;
    int    lin;
    int    len;
    bit    nz;
    bit    act;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          lin_wr, ctrl_in, len_wr, len_halt, enable, qtr_tick, half_tick;
  logic [LW-1:0] reload_in;
  logic [NW-1:0] len_in;
  logic [LW-1:0] linear_count;
  logic [NW-1:0] length_count;
  logic          length_nz, active;

  exp_t sb[$];
  logic chkReq = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  apu_duration_counter dut (
    .clk          (clk),
    .reset        (reset),
    .lin_wr       (lin_wr),
    .ctrl_in      (ctrl_in),
    .reload_in    (reload_in),
    .len_wr       (len_wr),
    .len_in       (len_in),
    .len_halt     (len_halt),
    .enable       (enable),
    .qtr_tick     (qtr_tick),
    .half_tick    (half_tick),
    .linear_count (linear_count),
    .length_count (length_count),
    .length_nz    (length_nz),
    .active       (active)
  );

  // Monitor: one queued expectation per check request.
  always @(negedge clk) begin
    if (chkReq) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL monitor: check requested with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        total += 4;
        if (int'(linear_count) != e.lin) begin
          bad++; $display("FAIL %s linear_count: got %0d want %0d", e.name, linear_count, e.lin);
        end
        if (int'(length_count) != e.len) begin
          bad++; $display("FAIL %s length_count: got %0d want %0d", e.name, length_count, e.len);
        end
        if (length_nz !== e.nz) begin
          bad++; $display("FAIL %s length_nz: got %0b want %0b", e.name, length_nz, e.nz);
        end
        if (active !== e.act) begin
          bad++; $display("FAIL %s active: got %0b want %0b", e.name, active, e.act);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    lin_wr = 0; len_wr = 0; qtr_tick = 0; half_tick = 0; chkReq = 0;
  endtask

  task automatic expect_out(input string nm, input int lin, input int len);
    exp_t e;
    e.name = nm;
    e.lin  = lin;
    e.len  = len;
    e.nz   = (len != 0);
    e.act  = enable && (lin != 0) && (len != 0);
    sb.push_back(e);
    chkReq = 1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; lin_wr = 0; ctrl_in = 0; reload_in = '0; len_wr = 0; len_in = '0;
    len_halt = 0; enable = 1; qtr_tick = 0; half_tick = 0;
    cyc(); cyc();
    reset = 0;
    expect_out("reset", 0, 0);

    // Linear countdown with control clear
    lin_wr = 1; ctrl_in = 0; reload_in = 7'd10; cyc();
    len_wr = 1; len_in = 8'd20; cyc();
    for (int k = 1; k <= 12; k++) begin
      qtr_tick = 1; cyc();
      expect_out($sformatf("countdown%0d", k), (k == 1) ? 10 : ((11 - k) > 0 ? 11 - k : 0), LEN_A);
    end

    // Control set: flag sticks, length halted
    lin_wr = 1; ctrl_in = 1; reload_in = 7'd10; cyc();
    len_wr = 1; len_in = 8'd20; cyc();
    for (int k = 1; k <= 5; k++) begin
      qtr_tick = 1; cyc();
      expect_out($sformatf("ctrl_hold%0d", k), 10, LEN_A);
    end
    half_tick = 1; cyc();
    expect_out("halt_by_ctrl", 10, LEN_A);

    // Length load and half-frame decrements
    lin_wr = 1; ctrl_in = 0; reload_in = 7'd10; cyc();
    len_wr = 1; len_in = 8'd33; cyc();
    expect_out("len_load", 10, LEN_B);
    for (int k = 0; k < 3; k++) begin
      half_tick = 1; cyc();
    end
    expect_out("len_dec3", 10, LEN_B3);
    qtr_tick = 1; cyc();
    expect_out("reload_clear", 10, LEN_B3);
    qtr_tick = 1; cyc();
    expect_out("after_clear", 9, LEN_B3);

    // Disable forces length to zero; write while disabled still arms reload
    enable = 0; cyc();
    expect_out("disabled", 9, 0);
    len_wr = 1; len_in = 8'd33; cyc();
    expect_out("wr_disabled", 9, 0);
    qtr_tick = 1; cyc();
    expect_out("flag_from_dis_wr", 10, 0);
    enable = 1; cyc();

    // Load wins over a same-cycle decrement
    len_wr = 1; len_in = 8'd5; half_tick = 1; cyc();
    expect_out("load_vs_half", 10, LEN_C);

    // Same-cycle write and quarter tick with the flag clear
    qtr_tick = 1; cyc();
    for (int k = 0; k < 7; k++) begin
      qtr_tick = 1; cyc();
    end
    expect_out("lin_at3", 3, LEN_C);
    len_wr = 1; len_in = 8'd5; qtr_tick = 1; cyc();
    expect_out("wr_and_qtr", 2, LEN_C);
    qtr_tick = 1; cyc();
    expect_out("flag_survived", 10, LEN_C);

    // Both ticks together apply independently
    qtr_tick = 1; half_tick = 1; cyc();
    expect_out("both_ticks", 9, LEN_C - 1);

    // Reset mid-count beats strobes
    lin_wr = 1; reload_in = 7'd7; cyc();
    len_wr = 1; len_in = 8'd20; cyc();
    qtr_tick = 1; cyc();
    expect_out("pre_reset", 7, LEN_A);
    reset = 1; qtr_tick = 1; half_tick = 1; len_wr = 1; lin_wr = 1; reload_in = 7'd9; cyc();
    reset = 0;
    expect_out("mid_reset", 0, 0);
    qtr_tick = 1; cyc();
    expect_out("reset_cleared_flag", 0, 0);

    repeat (3) cyc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
